// File: rtl/haze_window_pkg.sv
// Shared definitions for the window frame scheduler: FSM state encoding,
// counter width derivation and border flag bit positions.
package haze_window_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TOP_PAD,
        STREAM,
        BOT_PAD,
        DONE
    } state_t;

    localparam int BORDER_TOP    = 3;
    localparam int BORDER_BOTTOM = 2;
    localparam int BORDER_LEFT   = 1;
    localparam int BORDER_RIGHT  = 0;

    // Width of an image row index (win_row)
    function automatic int row_w(input int h);
        return $clog2(h);
    endfunction

    // Width of a column index (win_col)
    function automatic int col_w(input int w);
        return $clog2(w);
    endfunction

    // Stream row covers top pad, image rows and bottom pad: 0..h+1
    function automatic int stream_w(input int h);
        return $clog2(h + 2);
    endfunction

endpackage

// File: rtl/window_pos_counter.sv
// Column / stream-row position counter for the window frame scheduler.
// Ports: clk, rst (async active-low), adv (step one column), clr (sync clear),
//        col, row (stream row 0..IMG_HEIGHT+1), last_col, last_row.
module window_pos_counter
    import haze_window_pkg::*;
#(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    localparam int CW = col_w(IMG_WIDTH),
    localparam int SW = stream_w(IMG_HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          adv,
    input  logic          clr,
    output logic [CW-1:0] col,
    output logic [SW-1:0] row,
    output logic          last_col,
    output logic          last_row
);

    assign last_col = (col == CW'(IMG_WIDTH - 1));
    assign last_row = (row == SW'(IMG_HEIGHT + 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (adv) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + SW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/window_frame_scheduler.sv
// Frame sequencer for the 3-row line buffer: one pad row above and below
// the image, handshaked pixel intake, window position tags and border flags.
// Ports: clk, rst (async active-low), in_pixel/in_valid/in_ready (source),
//        lb_pixel/lb_valid (line-buffer write), win_valid/win_row/win_col,
//        border {top,bottom,left,right}, busy, frame_done.
// Build option: define WIN_BORDER_EN to compute border flags (else tied 0).
module window_frame_scheduler
    import haze_window_pkg::*;
#(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int PIXEL_W    = 24,
    parameter logic [PIXEL_W-1:0] PAD_VALUE = '0,
    localparam int ROW_W = row_w(IMG_HEIGHT),
    localparam int COL_W = col_w(IMG_WIDTH),
    localparam int SW    = stream_w(IMG_HEIGHT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PIXEL_W-1:0] in_pixel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [PIXEL_W-1:0] lb_pixel,
    output logic               lb_valid,
    output logic               win_valid,
    output logic [ROW_W-1:0]   win_row,
    output logic [COL_W-1:0]   win_col,
    output logic [3:0]         border,
    output logic               busy,
    output logic               frame_done
);

    state_t           state;
    logic [COL_W-1:0] col;
    logic [SW-1:0]    s;
    logic             last_col;
    logic             last_row;
    logic             xfer;
    logic             wr;
    logic             centre_ok;

    // in_ready is only ever high in STREAM, so xfer implies STREAM
    assign xfer      = in_valid && in_ready;
    assign wr        = (state == TOP_PAD) || (state == BOT_PAD) || xfer;
    // Two rows must be primed before the centre row exists
    assign centre_ok = (s >= SW'(2));

    window_pos_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT)
    ) u_pos (
        .clk      (clk),
        .rst      (rst),
        .adv      (wr),
        .clr      (state == IDLE),
        .col      (col),
        .row      (s),
        .last_col (last_col),
        .last_row (last_row)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            lb_pixel   <= '0;
            lb_valid   <= 1'b0;
            win_valid  <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            lb_valid   <= 1'b0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (wr) begin
                lb_valid  <= 1'b1;
                lb_pixel  <= (state == STREAM) ? in_pixel : PAD_VALUE;
                win_valid <= centre_ok;
                win_row   <= centre_ok ? ROW_W'(s - SW'(2)) : '0;
                win_col   <= col;
            end
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= TOP_PAD;
                        busy  <= 1'b1;
                    end
                end
                TOP_PAD: begin
                    if (last_col) begin
                        state    <= STREAM;
                        in_ready <= 1'b1;
                    end
                end
                STREAM: begin
                    if (xfer && last_col && s == SW'(IMG_HEIGHT)) begin
                        state    <= BOT_PAD;
                        in_ready <= 1'b0;
                    end
                end
                BOT_PAD: begin
                    if (last_col && last_row) state <= DONE;
                end
                DONE: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WIN_BORDER_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            border <= 4'b0000;
        end else begin
            border <= 4'b0000;
            if (wr && centre_ok) begin
                border[BORDER_TOP]    <= (s == SW'(2));
                border[BORDER_BOTTOM] <= last_row;
                border[BORDER_LEFT]   <= (col == '0);
                border[BORDER_RIGHT]  <= last_col;
            end
        end
    end
`else
    assign border = 4'b0000;
`endif

endmodule

// File: tb/tb_window_frame_scheduler.sv
// Directed bench for window_frame_scheduler at 4x3 with zero padding.
// Each scenario task drives a frame and compares against hand-derived values.
module tb_window_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] in_pixel = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] lb_pixel;
    logic        lb_valid;
    logic        win_valid;
    logic [1:0]  win_row;
    logic [1:0]  win_col;
    logic [3:0]  border;
    logic        busy;
    logic        frame_done;

    int checks = 0;
    int fails  = 0;

    logic [23:0] lb_q[$];
    int          lbcyc_q[$];
    logic [7:0]  win_q[$];
    int          cyc = 0;
    int          fd_cnt;
    logic        fd_ok;
    logic        prev_lb;
    int          ready_cnt;
    int          busy_cnt;
    int          first_ready;
    int          bad_border;
    int          tmo;

    window_frame_scheduler #(
        .IMG_WIDTH  (4),
        .IMG_HEIGHT (3),
        .PIXEL_W    (24),
        .PAD_VALUE  (24'h0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_pixel   (in_pixel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .lb_pixel   (lb_pixel),
        .lb_valid   (lb_valid),
        .win_valid  (win_valid),
        .win_row    (win_row),
        .win_col    (win_col),
        .border     (border),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] exp_lb(input int k, input logic [23:0] base);
        if (k < 4 || k >= 16) return 24'h0;
        return base + 24'(k - 3);
    endfunction

    function automatic logic [7:0] exp_win(input int k);
        logic [1:0] r;
        logic [1:0] c;
        logic [3:0] b;
        r = 2'(k / 4);
        c = 2'(k % 4);
        b = 4'b0000;
`ifdef WIN_BORDER_EN
        b = {r == 2'd0, r == 2'd2, c == 2'd0, c == 2'd3};
`endif
        return {r, c, b};
    endfunction

    function automatic logic [3:0] exp_border(input int r, input int c);
        logic [3:0] b;
        b = 4'b0000;
`ifdef WIN_BORDER_EN
        b = {r == 0, r == 2, c == 0, c == 3};
`endif
        return b;
    endfunction

    task automatic clear_stats();
        lb_q.delete();
        lbcyc_q.delete();
        win_q.delete();
        fd_cnt      = 0;
        fd_ok       = 1'b0;
        prev_lb     = 1'b0;
        ready_cnt   = 0;
        busy_cnt    = 0;
        first_ready = -1;
        bad_border  = 0;
        cyc         = 0;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (lb_valid) begin
            lb_q.push_back(lb_pixel);
            lbcyc_q.push_back(cyc);
        end
        if (win_valid) win_q.push_back({win_row, win_col, border});
        if (!win_valid && border != 4'b0000) bad_border++;
        if (win_valid && !lb_valid) bad_border++;
        if (in_ready) begin
            ready_cnt++;
            if (first_ready < 0) first_ready = cyc;
        end
        if (busy) busy_cnt++;
        if (frame_done) begin
            fd_cnt++;
            fd_ok = prev_lb && (lb_q.size() == 20);
        end
        prev_lb = lb_valid;
    endtask

    // Drives one frame; abort_at>0 stops after that many transfers
    task automatic run_frame(input int toggle, input logic [23:0] base,
                             input int dead_hold, input int abort_at);
        int   idx;
        int   dead;
        int   post;
        logic pend;
        clear_stats();
        idx  = 0;
        dead = 0;
        post = 0;
        tmo  = 1;
        @(negedge clk);
        in_pixel = base + 24'd1;
        in_valid = 1'b1;
        pend     = in_valid && in_ready;
        for (int n = 0; n < 300; n++) begin
            step();
            if (pend) idx++;
            if (abort_at > 0 && idx == abort_at) begin
                tmo = 0;
                break;
            end
            if (idx < 12) begin
                in_valid = (toggle != 0 && pend) ? 1'b0 : 1'b1;
                in_pixel = base + 24'(idx + 1);
            end else if (dead < dead_hold) begin
                in_valid = 1'b1;
                in_pixel = 24'hDEAD;
                dead++;
            end else begin
                in_valid = 1'b0;
            end
            pend = in_valid && in_ready;
            if (fd_cnt > 0) post++;
            if (post > 3) begin
                tmo = 0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({lb_valid, win_valid, busy, in_ready, frame_done, border,
             lb_pixel, win_row, win_col} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got lbv=%b wv=%b busy=%b rdy=%b fd=%b brd=%b px=%h",
                     lb_valid, win_valid, busy, in_ready, frame_done, border, lb_pixel);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, in_ready, lb_valid} !== 3'b000) begin
            fails++;
            $display("FAIL idle_after_reset got busy=%b rdy=%b lbv=%b want 000",
                     busy, in_ready, lb_valid);
        end
    endtask

    task automatic test_continuous();
        run_frame(0, 24'h0, 0, 0);
        checks++;
        if (tmo != 0) begin
            fails++;
            $display("FAIL cont_timeout got no frame_done within bound");
        end
        checks++;
        if (lb_q.size() != 20) begin
            fails++;
            $display("FAIL cont_lb_count got %0d want 20", lb_q.size());
        end
        for (int k = 0; k < 20 && k < lb_q.size(); k++) begin
            checks++;
            if (lb_q[k] !== exp_lb(k, 24'h0)) begin
                fails++;
                $display("FAIL cont_lb_px[%0d] got %h want %h", k, lb_q[k], exp_lb(k, 24'h0));
            end
        end
        checks++;
        if (win_q.size() != 12) begin
            fails++;
            $display("FAIL cont_win_count got %0d want 12", win_q.size());
        end
        for (int k = 0; k < 12 && k < win_q.size(); k++) begin
            checks++;
            if (win_q[k] !== exp_win(k)) begin
                fails++;
                $display("FAIL cont_win[%0d] got %h want %h", k, win_q[k], exp_win(k));
            end
        end
        checks++;
        if (fd_cnt != 1 || fd_ok !== 1'b1) begin
            fails++;
            $display("FAIL cont_frame_done got cnt=%0d aligned=%b want 1/1", fd_cnt, fd_ok);
        end
        checks++;
        if (ready_cnt != 12) begin
            fails++;
            $display("FAIL cont_ready_cycles got %0d want 12", ready_cnt);
        end
        checks++;
        if (busy_cnt != 21 || busy !== 1'b0) begin
            fails++;
            $display("FAIL cont_busy got cycles=%0d now=%b want 21/0", busy_cnt, busy);
        end
        checks++;
        if (lbcyc_q.size() < 16 || lbcyc_q[15] - lbcyc_q[4] != 11) begin
            fails++;
            $display("FAIL cont_data_span got %0d want 11",
                     lbcyc_q.size() >= 16 ? lbcyc_q[15] - lbcyc_q[4] : -1);
        end
        checks++;
        if (bad_border != 0) begin
            fails++;
            $display("FAIL cont_qualify got %0d stray flags want 0", bad_border);
        end
    endtask

    task automatic test_toggle();
        run_frame(1, 24'h000100, 0, 0);
        checks++;
        if (tmo != 0 || lb_q.size() != 20 || win_q.size() != 12 || fd_cnt != 1) begin
            fails++;
            $display("FAIL tog_counts got tmo=%0d lb=%0d win=%0d fd=%0d want 0/20/12/1",
                     tmo, lb_q.size(), win_q.size(), fd_cnt);
        end
        for (int k = 0; k < 20 && k < lb_q.size(); k++) begin
            checks++;
            if (lb_q[k] !== exp_lb(k, 24'h000100)) begin
                fails++;
                $display("FAIL tog_lb_px[%0d] got %h want %h", k, lb_q[k],
                         exp_lb(k, 24'h000100));
            end
        end
        checks++;
        if (lbcyc_q.size() < 16 || lbcyc_q[15] - lbcyc_q[4] != 22) begin
            fails++;
            $display("FAIL tog_data_span got %0d want 22",
                     lbcyc_q.size() >= 16 ? lbcyc_q[15] - lbcyc_q[4] : -1);
        end
        checks++;
        if (lbcyc_q.size() >= 6 && lbcyc_q[5] - lbcyc_q[4] != 2) begin
            fails++;
            $display("FAIL tog_gap got %0d want 2", lbcyc_q[5] - lbcyc_q[4]);
        end
    endtask

    task automatic test_border();
        logic [7:0] w;
        logic       seen00;
        logic       seen23;
        logic       seen11;
        run_frame(0, 24'h000200, 0, 0);
        seen00 = 1'b0;
        seen23 = 1'b0;
        seen11 = 1'b0;
        for (int k = 0; k < win_q.size(); k++) begin
            w = win_q[k];
            if (w[7:4] == 4'b0000) begin
                seen00 = 1'b1;
                checks++;
                if (w[3:0] !== exp_border(0, 0)) begin
                    fails++;
                    $display("FAIL border_r0c0 got %b want %b", w[3:0], exp_border(0, 0));
                end
            end
            if (w[7:4] == 4'b1011) begin
                seen23 = 1'b1;
                checks++;
                if (w[3:0] !== exp_border(2, 3)) begin
                    fails++;
                    $display("FAIL border_r2c3 got %b want %b", w[3:0], exp_border(2, 3));
                end
            end
            if (w[7:4] == 4'b0101) begin
                seen11 = 1'b1;
                checks++;
                if (w[3:0] !== exp_border(1, 1)) begin
                    fails++;
                    $display("FAIL border_r1c1 got %b want %b", w[3:0], exp_border(1, 1));
                end
            end
        end
        checks++;
        if ({seen00, seen23, seen11} !== 3'b111 || bad_border != 0) begin
            fails++;
            $display("FAIL border_coverage got seen=%b stray=%0d want 111/0",
                     {seen00, seen23, seen11}, bad_border);
        end
    endtask

    task automatic test_reset_mid();
        run_frame(0, 24'h000300, 0, 6);
        checks++;
        if (tmo != 0 || busy !== 1'b1 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_reached_stream got tmo=%0d busy=%b rdy=%b want 0/1/1",
                     tmo, busy, in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({lb_valid, win_valid, busy, in_ready, frame_done, border,
             lb_pixel, win_row, win_col} !== '0) begin
            fails++;
            $display("FAIL mid_reset_outputs got lbv=%b wv=%b busy=%b rdy=%b px=%h",
                     lb_valid, win_valid, busy, in_ready, lb_pixel);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_frame(0, 24'h000400, 0, 0);
        checks++;
        if (tmo != 0 || lb_q.size() != 20 || win_q.size() != 12 || fd_cnt != 1) begin
            fails++;
            $display("FAIL mid_next_counts got tmo=%0d lb=%0d win=%0d fd=%0d want 0/20/12/1",
                     tmo, lb_q.size(), win_q.size(), fd_cnt);
        end
        for (int k = 0; k < 5 && k < lb_q.size(); k++) begin
            checks++;
            if (lb_q[k] !== exp_lb(k, 24'h000400)) begin
                fails++;
                $display("FAIL mid_next_px[%0d] got %h want %h", k, lb_q[k],
                         exp_lb(k, 24'h000400));
            end
        end
    endtask

    task automatic test_pad_holdoff();
        int dead_seen;
        run_frame(0, 24'h000500, 4, 0);
        checks++;
        if (first_ready != 5) begin
            fails++;
            $display("FAIL hold_top_pad got first ready at %0d want 5", first_ready);
        end
        checks++;
        if (ready_cnt != 12 || lb_q.size() != 20 || fd_cnt != 1) begin
            fails++;
            $display("FAIL hold_counts got rdy=%0d lb=%0d fd=%0d want 12/20/1",
                     ready_cnt, lb_q.size(), fd_cnt);
        end
        dead_seen = 0;
        for (int k = 0; k < lb_q.size(); k++) begin
            if (lb_q[k] == 24'hDEAD) dead_seen++;
        end
        checks++;
        if (dead_seen != 0) begin
            fails++;
            $display("FAIL hold_bot_pad got %0d held pixels written want 0", dead_seen);
        end
        for (int k = 16; k < 20 && k < lb_q.size(); k++) begin
            checks++;
            if (lb_q[k] !== 24'h0) begin
                fails++;
                $display("FAIL hold_pad_px[%0d] got %h want 000000", k, lb_q[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_toggle();
        test_border();
        test_reset_mid();
        test_pad_holdoff();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
